// File: rtl/vu_meter_ctrl.sv
// Windowed stereo peak meter: tracks the peak |(L+R)/2| per window and drives a 16-segment bar.
// Optional decaying peak-hold dot is built only when VU_PEAK_HOLD_EN is defined.
module vu_meter_ctrl #(
    parameter int unsigned WINDOW_SAMPLES = 256,
    parameter int unsigned HOLD_FRAMES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [31:0] sample_in,
    output logic [15:0] leds,
    output logic        frame_tick
);

    if (WINDOW_SAMPLES < 2 || WINDOW_SAMPLES > 65535) begin : g_bad_window
        $error("vu_meter_ctrl: WINDOW_SAMPLES out of range");
    end
    if (HOLD_FRAMES > 255) begin : g_bad_hold
        $error("vu_meter_ctrl: HOLD_FRAMES out of range");
    end

    typedef enum logic [1:0] {
        ACCUM,
        COMPUTE,
        APPLY
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(WINDOW_SAMPLES - 1);

    state_t      state, state_next;
    logic signed [16:0] sum;
    logic [15:0] avg;
    logic [15:0] avg_neg;
    logic [14:0] mag;
    logic [14:0] acc_peak, peak_next, snap_peak;
    logic [15:0] sample_cnt;
    logic        window_end;
    logic [4:0]  level, level_r;
    logic [15:0] bar;
    logic [15:0] leds_next;

    always_comb begin
        sum     = $signed({sample_in[31], sample_in[31:16]}) + $signed({sample_in[15], sample_in[15:0]});
        avg     = 16'(sum >>> 1);
        avg_neg = 16'(~avg + 16'd1);
        // The only average whose magnitude does not fit 15 bits is -32768.
        if (avg == 16'h8000) begin
            mag = 15'h7FFF;
        end else if (avg[15]) begin
            mag = avg_neg[14:0];
        end else begin
            mag = avg[14:0];
        end
        peak_next  = (mag > acc_peak) ? mag : acc_peak;
        window_end = sample_valid && (sample_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_peak   <= '0;
            snap_peak  <= '0;
            sample_cnt <= '0;
        end else if (sample_valid) begin
            if (window_end) begin
                snap_peak  <= peak_next;
                acc_peak   <= '0;
                sample_cnt <= '0;
            end else begin
                acc_peak   <= peak_next;
                sample_cnt <= sample_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // A window closing during APPLY chains straight into the next COMPUTE.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (window_end) state_next = COMPUTE;
            COMPUTE: state_next = APPLY;
            APPLY:   state_next = window_end ? COMPUTE : ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        level = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_peak > 15'(i * 1024)) begin
                level = level + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= '0;
        end else if (state == COMPUTE) begin
            level_r <= level;
        end
    end

    always_comb begin
        bar = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            bar[k] = (level_r > 5'(k));
        end
    end

`ifdef VU_PEAK_HOLD_EN
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

    logic [4:0]  hold_pos, hold_pos_next;
    logic [7:0]  hold_cnt, hold_cnt_next;
    logic [15:0] dot;

    always_comb begin
        hold_pos_next = hold_pos;
        hold_cnt_next = hold_cnt;
        if (level_r >= hold_pos) begin
            hold_pos_next = level_r;
            hold_cnt_next = HOLD_INIT;
        end else if (hold_cnt != 8'd0) begin
            hold_cnt_next = hold_cnt - 8'd1;
        end else if (hold_pos != 5'd0) begin
            hold_pos_next = hold_pos - 5'd1;
        end
        dot = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            dot[k] = (hold_pos_next == 5'(k + 1));
        end
        leds_next = bar | dot;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pos <= '0;
            hold_cnt <= '0;
        end else if (state == APPLY) begin
            hold_pos <= hold_pos_next;
            hold_cnt <= hold_cnt_next;
        end
    end
`else
    always_comb begin
        leds_next = bar;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (state == APPLY);
            if (state == APPLY) begin
                leds <= leds_next;
            end
        end
    end

endmodule

// File: tb/tb_vu_meter_ctrl.sv
// Directed scoreboard bench for vu_meter_ctrl (WINDOW_SAMPLES=4, HOLD_FRAMES=2).
// Expected frames follow the VU_PEAK_HOLD_EN build setting.
module tb_vu_meter_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic [15:0] leds;
    logic        frame_tick;

    typedef struct {
        int unsigned due;
        logic [15:0] leds;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] shown = '0;

    vu_meter_ctrl #(.WINDOW_SAMPLES(4), .HOLD_FRAMES(2)) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sample_in(sample_in),
        .leds(leds),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            shown = '0;
            nvec++;
            assert (leds === 16'h0000 && frame_tick === 1'b0) else begin
                nerr++;
                $error("FAIL reset_out leds=%h tick=%b expected leds=0000 tick=0", leds, frame_tick);
            end
        end else if (frame_tick) begin
            nvec++;
            assert (sb.size() != 0) else begin
                nerr++;
                $error("FAIL unexpected_tick leds=%h expected no frame_tick", leds);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                nvec++;
                assert (cyc === e.due) else begin
                    nerr++;
                    $error("FAIL %s_latency cycle=%0d expected %0d", e.tag, cyc, e.due);
                end
                nvec++;
                assert (leds === e.leds) else begin
                    nerr++;
                    $error("FAIL %s leds=%h expected %h", e.tag, leds, e.leds);
                end
                shown = e.leds;
            end
        end else begin
            nvec++;
            assert (leds === shown) else begin
                nerr++;
                $error("FAIL leds_hold leds=%h expected %h", leds, shown);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        nvec++;
        assert (sb.size() == 0) else begin
            nerr++;
            $error("FAIL frame_timeout pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        drain();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send(input logic [31:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        sample_in    = $urandom;
    endtask

    task automatic window(input logic [31:0] s, input logic [15:0] e, input string tag, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sample_in = $urandom;
                    @(posedge clk); #1;
                end
            end
            send(s);
        end
        sb.push_back('{cyc + 2, e, tag});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        sample_valid = 1'b1;
        repeat (3) begin
            sample_in = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        repeat (3) begin
            sample_in = $urandom;
            @(negedge clk);
            nvec++;
            assert (frame_tick === 1'b0) else begin
                nerr++;
                $error("FAIL post_reset_tick tick=%b expected 0", frame_tick);
            end
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;

        do_reset();
        window(32'h1400_1400, 16'h001F, "pos5120", 1'b0);
        do_reset();
        window(32'hEC00_EC00, 16'h001F, "neg5120", 1'b0);
        do_reset();
        window(32'h03E8_F448, 16'h0001, "mixed1000", 1'b0);
        do_reset();
        window(32'h8000_8000, 16'hFFFF, "saturate", 1'b0);

        do_reset();
        window(32'h8000_8000, 16'hFFFF, "hold0", 1'b1);
`ifdef VU_PEAK_HOLD_EN
        window(32'h0000_0000, 16'h8000, "hold1", 1'b1);
        window(32'h0000_0000, 16'h8000, "hold2", 1'b1);
        window(32'h0000_0000, 16'h4000, "hold3", 1'b1);
        window(32'h0000_0000, 16'h2000, "hold4", 1'b1);
`else
        window(32'h0000_0000, 16'h0000, "hold1", 1'b1);
        window(32'h0000_0000, 16'h0000, "hold2", 1'b1);
        window(32'h0000_0000, 16'h0000, "hold3", 1'b1);
        window(32'h0000_0000, 16'h0000, "hold4", 1'b1);
`endif

        do_reset();
        send(32'h7FFF_7FFF);
        send(32'h7FFF_7FFF);
        do_reset();
        window(32'h0000_0000, 16'h0000, "reset_mid", 1'b0);

        drain();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
